// File: rtl/mem_arbiter.sv
// Shared-bus arbiter for instruction fetch and data access.
// Runs a single bus transaction at a time, with timeout and fairness.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        bus_busy,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      st;
    logic        own_d;
    logic        op_wr;
    logic [1:0]  streak;
    logic [7:0]  wcnt;
    logic        d_req;
    logic        d_win;
    logic        finish;
    logic [31:0] rdata_cap;

    assign state = st;
    assign d_req = d_read | d_write;
    // Data normally wins; after three straight data wins a waiting fetch goes first.
    assign d_win = d_req & ~(i_req & (streak == 2'd3));
    assign finish = bus_ack | (wcnt == 8'hff);
    assign rdata_cap = bus_ack ? bus_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            own_d     <= 1'b0;
            op_wr     <= 1'b0;
            streak    <= 2'd0;
            wcnt      <= 8'd0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (d_req | i_req) begin
                        own_d     <= d_win;
                        op_wr     <= d_win & d_write;
                        bus_addr  <= d_win ? d_addr : i_addr;
                        bus_wdata <= d_win ? d_wdata : 32'd0;
                        streak    <= (d_win & i_req) ? streak + 2'd1 : 2'd0;
                        bus_read  <= ~(d_win & d_write);
                        bus_write <= d_win & d_write;
                        st        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus_busy) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        wcnt      <= 8'd0;
                        st        <= WAIT;
                    end
                end
                WAIT: begin
                    if (finish) begin
                        st     <= DONE;
                        err    <= ~bus_ack;
                        d_done <= own_d;
                        i_done <= ~own_d;
                        if (!op_wr && own_d) d_rdata <= rdata_cap;
                        if (!op_wr && !own_d) i_rdata <= rdata_cap;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                DONE: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        bus_busy = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] i_rdata;
    logic        i_done;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        err;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_read(d_read), .d_write(d_write),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .i_rdata(i_rdata), .i_done(i_done),
        .d_rdata(d_rdata), .d_done(d_done),
        .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Transaction-level model: phase 0..3 = idle/command/waiting/complete.
    int          m_ph = 0;
    int          m_cnt = 0;
    int          m_streak = 0;
    bit          m_own_d = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_i_rdata = 32'd0;
    logic [31:0] m_d_rdata = 32'd0;

    function automatic bit data_wins(bit ireq, bit dreq, int strk);
        return dreq && !(ireq && strk == 3);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph      <= 0;
            m_cnt     <= 0;
            m_streak  <= 0;
            m_own_d   <= 1'b0;
            m_wr      <= 1'b0;
            m_err     <= 1'b0;
            m_i_rdata <= 32'd0;
            m_d_rdata <= 32'd0;
        end else if (m_ph == 0) begin
            if (i_req || d_read || d_write) begin
                m_own_d  <= data_wins(i_req, d_read || d_write, m_streak);
                m_wr     <= data_wins(i_req, d_read || d_write, m_streak) && d_write;
                m_addr   <= data_wins(i_req, d_read || d_write, m_streak) ? d_addr : i_addr;
                m_wdata  <= d_wdata;
                m_streak <= (data_wins(i_req, d_read || d_write, m_streak) && i_req)
                            ? m_streak + 1 : 0;
                m_ph     <= 1;
            end
        end else if (m_ph == 1) begin
            if (!bus_busy) begin
                m_ph  <= 2;
                m_cnt <= 0;
            end
        end else if (m_ph == 2) begin
            if (bus_ack || m_cnt == 255) begin
                m_ph  <= 3;
                m_err <= !bus_ack;
                if (!m_wr && m_own_d) m_d_rdata <= bus_ack ? bus_rdata : 32'd0;
                if (!m_wr && !m_own_d) m_i_rdata <= bus_ack ? bus_rdata : 32'd0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_ph <= 0;
        end
    end

    always @(negedge clk) begin
        chk("state", 32'(state), 32'(m_ph));
        chk("bus_read", 32'(bus_read), 32'(m_ph == 1 && !m_wr));
        chk("bus_write", 32'(bus_write), 32'(m_ph == 1 && m_wr));
        if (m_ph == 1) chk("bus_addr", bus_addr, m_addr);
        if (m_ph == 1 && m_wr) chk("bus_wdata", bus_wdata, m_wdata);
        chk("i_done", 32'(i_done), 32'(m_ph == 3 && !m_own_d));
        chk("d_done", 32'(d_done), 32'(m_ph == 3 && m_own_d));
        chk("err", 32'(err), 32'(m_ph == 3 && m_err));
        chk("i_rdata", i_rdata, m_i_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
    end

    int       ng;
    int       cnt;
    logic [4:0] pat;

    initial begin
        repeat (3) step();
        chk("rst_ctrl", 32'({state, bus_read, bus_write, i_done, d_done, err}), 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        rst = 1'b1;
        step();

        // Fetch
        i_req = 1'b1; i_addr = 32'h100; bus_rdata = 32'hDEADBEEF;
        step();
        chk("fetch_issue", 32'({state, bus_read, bus_write}), 32'b0110);
        chk("fetch_addr", bus_addr, 32'h100);
        i_req = 1'b0;
        step();
        bus_ack = 1'b1;
        step();
        chk("fetch_done", 32'({i_done, d_done, err}), 32'b100);
        chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
        bus_ack = 1'b0;
        step();
        chk("fetch_idle", 32'({state, i_done}), 32'd0);

        // Contention
        i_req = 1'b1; d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
        bus_ack = 1'b1;
        ng = 0; pat = 5'd0;
        for (int k = 0; k < 40 && ng < 5; k++) begin
            step();
            if (state == 2'd1) begin
                pat = {pat[3:0], bus_write};
                if (bus_write) chk("cont_wdata", bus_wdata, 32'h55);
                ng++;
            end
        end
        chk("cont_grants", 32'(pat), 32'b11101);
        i_req = 1'b0; d_write = 1'b0;
        for (int k = 0; k < 10 && state != 2'd0; k++) step();
        bus_ack = 1'b0;

        // Busy stall
        d_read = 1'b1; d_addr = 32'h40; bus_busy = 1'b1;
        step();
        d_read = 1'b0;
        cnt = 0;
        repeat (4) begin
            if (state == 2'd1 && bus_read) cnt++;
            step();
        end
        if (state == 2'd1 && bus_read) cnt++;
        bus_busy = 1'b0;
        step();
        chk("stall_issue_cycles", 32'(cnt), 32'd5);
        chk("stall_wait", 32'(state), 32'd2);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        step();
        chk("stall_done", 32'({d_done, err}), 32'b10);
        chk("stall_rdata", d_rdata, 32'h12345678);
        bus_ack = 1'b0;
        step();

        // Timeout
        d_read = 1'b1; d_addr = 32'h80;
        step();
        d_read = 1'b0;
        step();
        cnt = 0;
        for (int k = 0; k < 300 && state == 2'd2; k++) begin
            cnt++;
            step();
        end
        chk("tmo_wait_cycles", 32'(cnt), 32'd256);
        chk("tmo_done", 32'({state, d_done, err}), 32'b1111);
        chk("tmo_rdata", d_rdata, 32'd0);
        step();

        // Reset mid-WAIT
        d_read = 1'b1; d_addr = 32'h90;
        step();
        d_read = 1'b0;
        repeat (3) step();
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({state, bus_read, bus_write, i_done, d_done, err}), 32'd0);
        chk("rst_mid_rdata", i_rdata | d_rdata, 32'd0);
        #1 rst = 1'b1;
        bus_ack = 1'b1;
        cnt = 0;
        repeat (6) begin
            step();
            if (i_done || d_done || state != 2'd0) cnt++;
        end
        chk("rst_no_done", 32'(cnt), 32'd0);
        bus_ack = 1'b0;

        // Read and write together
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'hA0; d_wdata = 32'h77;
        step();
        chk("both_issue", 32'({bus_read, bus_write}), 32'b01);
        d_read = 1'b0; d_write = 1'b0;
        bus_ack = 1'b1;
        step();
        step();
        chk("both_done", 32'({d_done, i_done}), 32'b10);
        bus_ack = 1'b0;
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            i_req     = ($urandom_range(0, 2) == 0);
            d_read    = ($urandom_range(0, 2) == 0);
            d_write   = ($urandom_range(0, 3) == 0);
            i_addr    = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            bus_busy  = ($urandom_range(0, 3) == 0);
            bus_ack   = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
